// File: rtl/inst_rom_resp.sv
// inst_rom_resp: loadable instruction store with a wait-state fetch FSM (IDLE/WAIT/RESP); define INST_ROM_ERR_EN to add access-fault responses
module inst_rom_resp #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_o,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        rvalid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        err_o,
  input  logic        prog_we_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_data_i
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0] CNT_INIT = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q;
  logic [3:0] cnt_q;
  logic [31:0] addr_q, inst_q, inst_addr_q;
  logic rvalid_q, err_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] f_addr, f_off, p_off;
  logic [AW-1:0] f_idx;
  logic f_err, p_ok, enter_resp;
  assign gnt_o = req_i & ~flush_i & ~rst_i & (state_q == IDLE | (state_q == RESP & ~hold_i));
  assign f_addr = state_q == WAIT ? addr_q : addr_i;
  assign f_off = f_addr - BASE_ADDR;
  assign f_idx = f_off[AW+1:2];
  assign p_off = prog_addr_i - BASE_ADDR;
  assign p_ok = prog_we_i & ~|prog_addr_i[1:0] & prog_addr_i >= BASE_ADDR & {1'b0, p_off} < SPAN;
`ifdef INST_ROM_ERR_EN
  assign f_err = |f_addr[1:0] | f_addr < BASE_ADDR | {1'b0, f_off} >= SPAN;
`else
  assign f_err = 1'b0;
`endif
  assign enter_resp = (gnt_o & WAIT_CYCLES == 0) | (state_q == WAIT & cnt_q == 4'd0);
  // loader writes land on the edge; a same-edge fetch capture still sees the old word
  always_ff @(posedge clk_i)
    if (p_ok) mem_q[p_off[AW+1:2]] <= prog_data_i;
  // fetch FSM: reset > flush > response capture > grant > wait countdown > release
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
      inst_q <= NOP;
      inst_addr_q <= 32'd0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      rvalid_q <= 1'b0;
    end else if (enter_resp) begin
      state_q <= RESP;
      rvalid_q <= 1'b1;
      inst_q <= f_err ? NOP : mem_q[f_idx];
      inst_addr_q <= f_addr;
      err_q <= f_err;
    end else if (gnt_o) begin
      state_q <= WAIT;
      cnt_q <= CNT_INIT;
      addr_q <= addr_i;
      rvalid_q <= 1'b0;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - 4'd1;
    end else if (state_q == RESP & ~hold_i) begin
      state_q <= IDLE;
      rvalid_q <= 1'b0;
    end
  assign rvalid_o = rvalid_q;
  assign inst_o = inst_q;
  assign inst_addr_o = inst_addr_q;
  assign err_o = err_q;
endmodule

// File: doc/inst_rom_resp.md
INST_ROM_RESP -- requirements
Module: inst_rom_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, giving the instruction store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, giving the wait states inserted before each response (legal range 0..15).
REQ-004 SHALL have ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  1  fetch request from the core.
- addr_i  in  32 (`INST_ADDR_BUS`)  fetch byte address (core pc_addr_o).
- gnt_o  out  1  request accepted this cycle.
- hold_i  in  1  core stall; freezes a pending response.
- flush_i  in  1  core jump or flush; discards in-flight fetch.
- rvalid_o  out  1  response valid.
- inst_o  out  32 (`INST_DATA_BUS`)  instruction word, to the core's rib_inst_i.
- inst_addr_o  out  32  address of inst_o, to the core's rib_inst_addr_i.
- err_o  out  1  access fault, qualified by rvalid_o.
- prog_we_i  in  1  loader write enable.
- prog_addr_i  in  32  loader word-aligned byte address.
- prog_data_i  in  32  loader write data.

Function
REQ-005 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-006 gnt_o SHALL be combinational, equal to req_i & !flush_i & (state==IDLE | (state==RESP & !hold_i)).
REQ-007 On grant, addr_i SHALL be latched: WAIT_CYCLES>0 goes to WAIT with counter=WAIT_CYCLES-1; WAIT_CYCLES==0 goes to RESP.
REQ-008 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where counter==0.
REQ-009 A fetch granted at edge N SHALL give rvalid_o=1 during cycle N+1+WAIT_CYCLES.
REQ-010 In RESP with hold_i=1: rvalid_o, inst_o, inst_addr_o and err_o SHALL hold; no new grant.
REQ-011 In RESP with hold_i=0: a granted request SHALL proceed as REQ-007 (back-to-back); with no grant, state goes to IDLE and rvalid_o deasserts.
REQ-012 flush_i=1 in any state SHALL force IDLE on the next edge, with rvalid_o=0 and no grant; flush has priority over hold_i and req_i.
REQ-013 Read data and inst_addr_o SHALL be captured on the edge entering RESP; inst_addr_o SHALL equal the latched addr_i.
REQ-014 Word index SHALL be (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
REQ-015 prog_we_i SHALL write prog_data_i at the index of prog_addr_i on the edge; out-of-range or misaligned writes are ignored.
REQ-016 A write and a RESP capture to the same word on the same edge SHALL return the old data.
REQ-017 outside RESP, rvalid_o SHALL be 0; inst_o and inst_addr_o SHALL keep their last values.

Reset
REQ-018 rst_i=1 SHALL force, at the next edge: state=IDLE, counter=0, rvalid_o=0, err_o=0, inst_o=32'h0000_0013 (NOP), inst_addr_o=0.
REQ-019 Reset asserted mid-fetch SHALL drop that fetch; gnt_o SHALL be 0 while rst_i=1.
REQ-020 Storage contents SHALL NOT be reset.

Configuration
REQ-021 Macro INST_ROM_ERR_EN, when defined: misaligned (addr[1:0]!=0) or out-of-range (below BASE_ADDR or at/above BASE_ADDR+4*DEPTH_WORDS) fetches SHALL respond with err_o=1 and inst_o=32'h0000_0013, with unchanged latency.
REQ-022 When INST_ROM_ERR_EN is undefined: err_o SHALL be tied 0, address bits [1:0] ignored, and the index SHALL wrap modulo DEPTH_WORDS.

Verification
REQ-023 WAIT_CYCLES=1, word 0 = 32'h0050_0093: req_i with addr 0x0 at edge N -> rvalid_o=1 in cycle N+2, inst_o=32'h0050_0093, inst_addr_o=0x0.
REQ-024 WAIT_CYCLES=0, req_i held high with addr 0x0, 0x4, 0x8 -> rvalid_o=1 for three consecutive cycles with inst_addr_o 0x0, 0x4, 0x8.
REQ-025 hold_i=1 for 3 cycles during RESP for addr 0x4 -> outputs stable for 3 cycles, gnt_o=0; after release, next fetch is granted.
REQ-026 flush_i=1 in WAIT (WAIT_CYCLES=3) -> no rvalid_o for that fetch; state IDLE; a new request the next cycle gives gnt_o=1.
REQ-027 INST_ROM_ERR_EN defined, addr 0x2 and addr BASE_ADDR+0x4000 (DEPTH_WORDS=4096) -> err_o=1, inst_o=32'h0000_0013; undefined -> err_o=0, and 0x4000 returns word 0.
REQ-028 rst_i=1 one cycle mid-WAIT -> rvalid_o=0, inst_o=32'h0000_0013, inst_addr_o=0 the next cycle, with no stale response afterwards.
